// File: rtl/sar_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the SAR conversion sequencer.
package sar_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        CMP    = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } sar_state_t;

    localparam int OVERRUN_W = 8;

    // Width of a phase counter able to count the longest of the three phases.
    function automatic int phase_cnt_w(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (c > m) ? c : m;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sar_out_reg.sv
// One-deep valid/ready result register with a saturating dropped-word counter.
module sar_out_reg
    import sar_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [W-1:0]         data_i,
    input  logic                 err_i,
    input  logic                 ready_i,
    output logic [W-1:0]         data_o,
    output logic                 err_o,
    output logic                 valid_o,
    output logic [OVERRUN_W-1:0] overrun_o
);

    localparam logic [OVERRUN_W-1:0] OVR_MAX = {OVERRUN_W{1'b1}};
    localparam logic [OVERRUN_W-1:0] OVR_ONE = {{(OVERRUN_W-1){1'b0}}, 1'b1};

    logic [W-1:0]         data_q, data_d;
    logic                 err_q, err_d;
    logic                 valid_q, valid_d;
    logic [OVERRUN_W-1:0] ovr_q, ovr_d;
    logic                 xfer_s;

    // Next-state: a load wins when the slot is free or being drained, else it is counted as dropped.
    always_comb begin
        data_d  = data_q;
        err_d   = err_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        xfer_s  = valid_q & ready_i;
        if (load_i) begin
            if (valid_q && !xfer_s) begin
                if (ovr_q != OVR_MAX) begin
                    ovr_d = ovr_q + OVR_ONE;
                end else begin
                    ovr_d = ovr_q;
                end
            end else begin
                data_d  = data_i;
                err_d   = err_i;
                valid_d = 1'b1;
            end
        end else if (xfer_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= {W{1'b0}};
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= {OVERRUN_W{1'b0}};
        end else begin
            data_q  <= data_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o    = data_q;
    assign err_o     = err_q;
    assign valid_o   = valid_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/sar_seq_ctrl.sv
// Clocked SAR conversion sequencer: sample, per-bit comparison with timeout, DAC steering.
module sar_seq_ctrl
    import sar_ctrl_pkg::*;
#(
    parameter int ADC_BITS    = 8,
    parameter int SAMPLE_CYC  = 2,
    parameter int SETTLE_CYC  = 1,
    parameter int CMP_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 sample,
    output logic                 cmp_clk,
    input  logic                 cmp_done,
    input  logic                 cmp_out,
    output logic [1:ADC_BITS-1]  dac_data_h,
    output logic [1:ADC_BITS-1]  dac_data_l,
    output logic [ADC_BITS-1:0]  dout,
    output logic                 dout_err,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [OVERRUN_W-1:0] overrun_cnt
);

    localparam int CW = phase_cnt_w(SAMPLE_CYC, SETTLE_CYC, CMP_TIMEOUT);
    localparam int IW = $clog2(ADC_BITS + 1);

    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] CMP_LAST    = CW'(CMP_TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_ONE     = IW'(1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(ADC_BITS);
    localparam logic [1:ADC_BITS-1] DAC_ZERO = {(ADC_BITS-1){1'b0}};

    sar_state_t            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [1:ADC_BITS-1]   dac_h_q, dac_h_d, dac_l_q, dac_l_d;
    logic [ADC_BITS-1:0]   res_q, res_d;
    logic                  err_q, err_d;
    logic                  busy_q, sample_q, cmp_clk_q;
    logic                  fire_s, dec_s, load_s;

    // Next-state, phase counting, result write and DAC steering.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        idx_d   = idx_q;
        dac_h_d = dac_h_q;
        dac_l_d = dac_l_q;
        res_d   = res_q;
        err_d   = err_q;
        fire_s  = 1'b0;
        dec_s   = 1'b0;
        load_s  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = CNT_ZERO;
                if (start) begin
                    state_d = SAMPLE;
                    idx_d   = IDX_ONE;
                end else begin
                    state_d = IDLE;
                end
            end
            SAMPLE: begin
                if (cnt_q == SAMPLE_LAST) begin
                    state_d = CMP;
                    cnt_d   = CNT_ZERO;
                    idx_d   = IDX_ONE;
                end else begin
                    state_d = SAMPLE;
                end
            end
            CMP: begin
                // The first strobe cycle gives the comparator no time to resolve, so cmp_done is not trusted there.
                if ((cnt_q != CNT_ZERO) && cmp_done) begin
                    fire_s = 1'b1;
                    dec_s  = cmp_out;
                end else if (cnt_q == CMP_LAST) begin
                    fire_s = 1'b1;
                    dec_s  = 1'b0;
                    err_d  = 1'b1;
                end else begin
                    fire_s = 1'b0;
                end
                if (fire_s) begin
                    for (int k = 0; k < ADC_BITS; k++) begin
                        if (k == (ADC_BITS - int'(idx_q))) begin
                            res_d[k] = dec_s;
                        end else begin
                            res_d[k] = res_q[k];
                        end
                    end
                    for (int k = 1; k < ADC_BITS; k++) begin
                        if (k == int'(idx_q)) begin
                            if (dec_s) begin
                                dac_l_d[k] = 1'b1;
                            end else begin
                                dac_h_d[k] = 1'b1;
                            end
                        end else begin
                            dac_l_d[k] = dac_l_q[k];
                        end
                    end
                    cnt_d = CNT_ZERO;
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else if (SETTLE_CYC > 0) begin
                        state_d = SETTLE;
                    end else begin
                        state_d = CMP;
                        idx_d   = idx_q + IDX_ONE;
                    end
                end else begin
                    state_d = CMP;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CMP;
                    cnt_d   = CNT_ZERO;
                    idx_d   = idx_q + IDX_ONE;
                end else begin
                    state_d = SETTLE;
                end
            end
            DONE: begin
                load_s  = 1'b1;
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
                idx_d   = IDX_ONE;
                dac_h_d = DAC_ZERO;
                dac_l_d = DAC_ZERO;
                res_d   = {ADC_BITS{1'b0}};
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
                idx_d   = IDX_ONE;
                dac_h_d = DAC_ZERO;
                dac_l_d = DAC_ZERO;
                err_d   = 1'b0;
            end
        endcase
    end

    // Sequencer state; control outputs are flopped from the next state so the comparator strobe is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            idx_q     <= IDX_ONE;
            dac_h_q   <= DAC_ZERO;
            dac_l_q   <= DAC_ZERO;
            res_q     <= {ADC_BITS{1'b0}};
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            sample_q  <= 1'b0;
            cmp_clk_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            dac_h_q   <= dac_h_d;
            dac_l_q   <= dac_l_d;
            res_q     <= res_d;
            err_q     <= err_d;
            busy_q    <= (state_d != IDLE);
            sample_q  <= (state_d == SAMPLE);
            cmp_clk_q <= (state_d == CMP);
        end
    end

    assign busy       = busy_q;
    assign sample     = sample_q;
    assign cmp_clk    = cmp_clk_q;
    assign dac_data_h = dac_h_q;
    assign dac_data_l = dac_l_q;

    sar_out_reg #(.W(ADC_BITS)) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load_s),
        .data_i    (res_q),
        .err_i     (err_q),
        .ready_i   (dout_ready),
        .data_o    (dout),
        .err_o     (dout_err),
        .valid_o   (dout_valid),
        .overrun_o (overrun_cnt)
    );

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// Self-checking bench for sar_seq_ctrl: comparator model, word scoreboard, vector table and corner sequences.
module tb_sar_seq_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n, start, cmp_done, cmp_out, dout_ready;
    logic         busy, sample, cmp_clk, dout_err, dout_valid;
    logic [1:N-1] dac_data_h, dac_data_l;
    logic [N-1:0] dout;
    logic [7:0]   overrun_cnt;

    typedef struct {
        logic [N-1:0] dout;
        logic         err;
    } word_t;

    typedef struct {
        logic [7:0] dec;
        int         hang;
        logic       junk;
        logic [7:0] exp_dout;
        logic       exp_err;
    } vec_t;

    word_t      sb_q[$];
    int         xfer_cyc[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         pops = 0;
    logic [7:0] cm_dec = 8'h00;
    int         cm_hang = N;
    logic       cm_junk = 1'b0;
    int         run = 0;
    int         cbit = N;
    int         runlen[0:N];

    sar_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .sample      (sample),
        .cmp_clk     (cmp_clk),
        .cmp_done    (cmp_done),
        .cmp_out     (cmp_out),
        .dac_data_h  (dac_data_h),
        .dac_data_l  (dac_data_l),
        .dout        (dout),
        .dout_err    (dout_err),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: note a pending transfer, advance to the falling edge, score it, then drive the comparator.
    task automatic step();
        logic  snap;
        word_t sw;
        snap    = dout_valid && dout_ready;
        sw.dout = dout;
        sw.err  = dout_err;
        @(negedge clk);
        cyc++;
        if (snap) begin
            pops++;
            xfer_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_word actual=%0h expected=none (cycle %0d)", sw.dout, cyc);
            end else begin
                word_t e;
                e = sb_q.pop_front();
                chk("sb_dout", sw.dout, e.dout);
                chk("sb_err", sw.err, e.err);
            end
        end
        if (cmp_clk) begin
            run++;
        end else begin
            if (run > 0) begin
                if (cbit <= N) runlen[cbit] = run;
                cbit++;
            end
            run = 0;
        end
        if (sample) cbit = 0;
        cmp_done = 1'b0;
        cmp_out  = 1'b0;
        if (cmp_clk && cbit < N) begin
            if (run == 1) begin
                if (cm_junk) begin
                    cmp_done = 1'b1;
                    cmp_out  = ~cm_dec[N-1-cbit];
                end
            end else if (cbit != cm_hang) begin
                cmp_done = 1'b1;
                cmp_out  = cm_dec[N-1-cbit];
            end
        end
    endtask

    // Full conversion; returns cycles from accepted start until busy drops. A start pulse is fired mid-conversion.
    task automatic run_conv(input logic [7:0] dec, input int hang, input logic junk,
                            input logic [7:0] exp, input logic exp_err, input logic push, output int lat);
        logic       dac_seen;
        logic [6:0] exp_l, exp_h;
        word_t      w;
        cm_dec   = dec;
        cm_hang  = hang;
        cm_junk  = junk;
        dac_seen = 1'b0;
        exp_l    = exp[N-1:1];
        exp_h    = ~exp_l;
        if (push) begin
            w.dout = exp;
            w.err  = exp_err;
            sb_q.push_back(w);
        end
        lat   = -1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 200; k++) begin
            if (!busy) begin
                lat = k;
                break;
            end
            if (cmp_clk && cbit == N-1 && !dac_seen) begin
                dac_seen = 1'b1;
                chk("dac_l_final", {25'd0, dac_data_l}, {25'd0, exp_l});
                chk("dac_h_final", {25'd0, dac_data_h}, {25'd0, exp_h});
            end
            start = (k == 5) ? 1'b1 : 1'b0;
            step();
        end
        start = 1'b0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL conv_timeout actual=busy expected=idle (cycle %0d)", cyc);
        end
    endtask

    vec_t vecs[8];
    int   lat;
    int   p0;
    int   saw;
    logic found;

    initial begin
        vecs[0] = '{8'hB2, N, 1'b0, 8'hB2, 1'b0};
        vecs[1] = '{8'hB2, N, 1'b1, 8'hB2, 1'b0};
        vecs[2] = '{8'hFF, 2, 1'b0, 8'hDF, 1'b1};
        vecs[3] = '{8'h00, N, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, N, 1'b1, 8'hFF, 1'b0};
        vecs[5] = '{8'hA5, 7, 1'b0, 8'hA4, 1'b1};
        vecs[6] = '{8'hA5, 0, 1'b0, 8'h25, 1'b1};
        vecs[7] = '{8'h3C, N, 1'b1, 8'h3C, 1'b0};

        rst_n = 1'b0; start = 1'b0; cmp_done = 1'b0; cmp_out = 1'b0; dout_ready = 1'b1;
        repeat (3) step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_sample", sample, 1'b0);
        chk("rst_cmp_clk", cmp_clk, 1'b0);
        chk("rst_dac_h", dac_data_h, 7'd0);
        chk("rst_dac_l", dac_data_l, 7'd0);
        chk("rst_dout", dout, 8'd0);
        chk("rst_dout_err", dout_err, 1'b0);
        chk("rst_dout_valid", dout_valid, 1'b0);
        chk("rst_overrun", overrun_cnt, 8'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Vector table with a free-running consumer.
        for (int v = 0; v < 8; v++) begin
            run_conv(vecs[v].dec, vecs[v].hang, vecs[v].junk, vecs[v].exp_dout, vecs[v].exp_err, 1'b1, lat);
            chk("latency", lat, 27 + ((vecs[v].hang < N) ? 2 : 0));
            chk("valid_rise", dout_valid, 1'b1);
            chk("idle_dac_h", dac_data_h, 7'd0);
            chk("idle_dac_l", dac_data_l, 7'd0);
            step();
            chk("valid_fall", dout_valid, 1'b0);
            if (vecs[v].hang < N) chk("timeout_cmp_len", runlen[vecs[v].hang], 4);
            else chk("normal_cmp_len", runlen[3], 2);
            step();
        end

        // Stalled consumer: three conversions, first word kept, two dropped.
        dout_ready = 1'b0;
        run_conv(8'h11, N, 1'b0, 8'h11, 1'b0, 1'b1, lat);
        run_conv(8'h22, N, 1'b0, 8'h22, 1'b0, 1'b0, lat);
        run_conv(8'h33, N, 1'b0, 8'h33, 1'b0, 1'b0, lat);
        step();
        chk("ovr_cnt2", overrun_cnt, 8'd2);
        chk("ovr_held_valid", dout_valid, 1'b1);
        chk("ovr_held_dout", dout, 8'h11);
        dout_ready = 1'b1;
        step();
        chk("ovr_valid_fall", dout_valid, 1'b0);

        // DONE lands on the same edge as a transfer.
        dout_ready = 1'b0;
        run_conv(8'h44, N, 1'b0, 8'h44, 1'b0, 1'b1, lat);
        cm_dec = 8'h55; cm_hang = N; cm_junk = 1'b0;
        sb_q.push_back('{8'h55, 1'b0});
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (busy && !cmp_clk && cbit == N) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("coinc_found_done", found, 1'b1);
        dout_ready = 1'b1;
        step();
        chk("coinc_valid", dout_valid, 1'b1);
        chk("coinc_dout", dout, 8'h55);
        chk("coinc_overrun", overrun_cnt, 8'd2);
        step();
        chk("coinc_valid_fall", dout_valid, 1'b0);

        // Saturation: one held word then 260 dropped ones.
        dout_ready = 1'b0;
        run_conv(8'h66, N, 1'b0, 8'h66, 1'b0, 1'b1, lat);
        for (int k = 0; k < 260; k++) run_conv(8'h77, N, 1'b0, 8'h77, 1'b0, 1'b0, lat);
        step();
        chk("ovr_saturated", overrun_cnt, 8'd255);
        dout_ready = 1'b1;
        repeat (2) step();

        // Asynchronous reset during bit 5 comparison.
        cm_dec = 8'hB2; cm_hang = N; cm_junk = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (cmp_clk && cbit == 4) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("rst_mid_found_bit5", found, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cmp_clk", cmp_clk, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_dac_h", dac_data_h, 7'd0);
        chk("rst_mid_dac_l", dac_data_l, 7'd0);
        repeat (2) step();
        rst_n = 1'b1;
        saw = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (dout_valid) saw++;
        end
        chk("rst_mid_no_word", saw, 0);
        chk("rst_mid_overrun", overrun_cnt, 8'd0);
        run_conv(8'hB2, N, 1'b0, 8'hB2, 1'b0, 1'b1, lat);
        chk("post_rst_latency", lat, 27);
        repeat (2) step();

        // Start held high: one conversion per 27 cycles.
        cm_dec = 8'h6D; cm_hang = N; cm_junk = 1'b0;
        xfer_cyc.delete();
        p0 = pops;
        for (int k = 0; k < 3; k++) sb_q.push_back('{8'h6D, 1'b0});
        start = 1'b1;
        repeat (60) step();
        start = 1'b0;
        repeat (100) step();
        chk("held_start_words", pops - p0, 3);
        if (xfer_cyc.size() == 3) begin
            chk("held_start_period1", xfer_cyc[1] - xfer_cyc[0], 27);
            chk("held_start_period2", xfer_cyc[2] - xfer_cyc[1], 27);
        end

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sar_seq_ctrl.md
Name: sar_seq_ctrl

Overview:
Synchronous conversion sequencer for the SAR ADC slice. It replaces the free-running asynchronous comparator clock with a clocked, bounded-time control loop.
- Drives the sample/hold phase, fires the comparator once per bit and applies each decision to the split-cap DAC controls.
- Guards every comparison with a metastability timeout.
- Hands the finished code to the back end through a 1-deep valid/ready output register with overrun counting.

Parameters:
ADC_BITS, 8, comparisons per conversion; DAC control vectors are [1:ADC_BITS-1]
SAMPLE_CYC, 2, clk cycles the sample phase is held (>=1)
SETTLE_CYC, 1, clk cycles of DAC settling after each DAC update (>=0)
CMP_TIMEOUT, 4, max clk cycles spent in one comparison, cmp_clk rise included (>=2)

Ports:
clk  input  1  controller clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  conversion request, sampled each cycle
busy  output  1  high from accepted start until the DONE cycle inclusive
sample  output  1  high during sample phase (S/H tracking)
cmp_clk  output  1  comparator strobe
cmp_done  input  1  comparator resolved
cmp_out  input  1  comparator decision (1 = vop > von)
dac_data_h  output  [1:ADC_BITS-1]  DAC bits switched to vrefp
dac_data_l  output  [1:ADC_BITS-1]  DAC bits switched to vrefn
dout  output  ADC_BITS  result code, MSB = first decision
dout_err  output  1  at least one comparison of this word timed out
dout_valid  output  1  output register holds an unread word
dout_ready  input  1  consumer accepts the word
overrun_cnt  output  8  dropped-word count, saturating

Behaviour:
- Reset, asynchronous and immediate, also mid-conversion:
  - state IDLE, all outputs 0, dac_data_h/dac_data_l all 0, bit index 1.
  - A conversion in flight is discarded; no partial word is emitted.
- States: IDLE, SAMPLE, CMP, SETTLE, DONE.
- IDLE:
  - start=1 -> SAMPLE next cycle; busy=1 from that cycle on.
  - start is ignored while busy=1; no queueing.
- SAMPLE:
  - sample=1 and DAC vectors held at 0 for exactly SAMPLE_CYC cycles, then -> CMP with bit i=1.
- CMP, bit i:
  - cmp_clk=1 on every CMP cycle.
  - cmp_done is ignored in the first CMP cycle and sampled from the 2nd cycle on.
  - First sampled cmp_done=1: capture d=cmp_out; cmp_clk=0 next cycle.
  - No cmp_done by the CMP_TIMEOUT-th CMP cycle: force d=0 and set the internal err flag.
  - Result write: dout bit (ADC_BITS-i) = d.
  - If i<ADC_BITS: d=1 sets dac_data_l[i]; d=0 sets dac_data_h[i]. Exactly one of h[i]/l[i] is set; already-set bits are never cleared within a conversion.
  - Next state after i<ADC_BITS: SETTLE if SETTLE_CYC>0, else CMP with i+1.
  - Next state after i=ADC_BITS: DONE, with no DAC update.
- SETTLE:
  - SETTLE_CYC cycles with cmp_clk=0, then CMP with i+1.
- DONE, one cycle:
  - Load output register, clear DAC vectors and err flag, go to IDLE (busy=0 from the next cycle).
- Latency with a comparator answering in the 2nd CMP cycle:
  - SAMPLE_CYC + 2*ADC_BITS + SETTLE_CYC*(ADC_BITS-1) + 1 cycles from the accepted start to the DONE cycle.
  - dout_valid rises the cycle after DONE: 26 + 1 for the default parameters.
- Output register:
  - Transfer occurs on dout_valid & dout_ready; dout_valid falls the next cycle unless a new word loads in that same cycle.
  - DONE while dout_valid=1 and dout_ready=0: new word dropped, old word kept, overrun_cnt += 1 (saturates at 255).
  - DONE in the same cycle as a transfer: new word loads, dout_valid stays 1, no overrun.
- Counters:
  - Phase counter is clog2(max(SAMPLE_CYC, SETTLE_CYC, CMP_TIMEOUT))+1 bits wide and resets on every state entry.
  - Bit index is clog2(ADC_BITS+1) bits wide.

Decomposition:
- Package sar_ctrl_pkg:
  - state enum sar_state_t {IDLE, SAMPLE, CMP, SETTLE, DONE}
  - clog2-based width helper
  - OVERRUN_W = 8
- One sub-module, sar_out_reg: the valid/ready output register plus overrun counter.
- The FSM, phase counter and DAC/result shift logic stay in sar_seq_ctrl.

Test Plan:
- Defaults; comparator returns cmp_done in the 2nd CMP cycle with decisions 1,0,1,1,0,0,1,0 -> dout=8'hB2, dout_err=0, dout_valid rises 27 cycles after start; dac_data_l[1:7]=1011001 and dac_data_h[1:7]=0100110 just before DONE.
- Comparator never asserts cmp_done on bit 3 (others return 1) -> bit 3 stays in CMP exactly 4 cycles; dout=8'hDF, dout_err=1; the next conversion with a normal comparator gives dout_err=0.
- dout_ready=0, three back-to-back conversions -> first word held, overrun_cnt=2; dout_ready=1 -> first word transferred and dout_valid falls; 260 forced overruns -> overrun_cnt=255.
- DONE coincides with dout_valid & dout_ready -> new word loads, dout_valid stays 1, overrun_cnt unchanged.
- rst_n pulsed low during bit 5 CMP -> same cycle: cmp_clk=0, busy=0, DAC vectors=0; no dout_valid afterwards; a fresh start converts normally.
- start held high continuously -> back-to-back conversions one per 27 cycles; start pulses during busy are ignored (no extra words).
